ama_riscv_writeback: RTL and testbench

Final pipeline stage of the core: registers the MEM-stage result bundle, aligns and sign/zero-extends load data from the synchronous data memory, selects the writeback source, and drives the register file write port (`we`/`addr_d`/`data_d`). It also exports the same write as a bypass source for operand forwarding and keeps a 64-bit retired-instruction counter.

---
 rtl/ama_riscv_writeback.sv | 145 ++++++++++++++
 tb/tb_ama_riscv_writeback.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_writeback.sv
// Writeback stage: registers the MEM bundle, aligns/extends load data, selects the
// register-file write source, mirrors it as a bypass, and counts retired instructions.
module ama_riscv_writeback #(
  parameter logic [31:0] RST_PC4 = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_reg_we,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wb_sel,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_pc_plus4,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] dmem_rdata,
  input  logic        wb_stall,
  input  logic        wb_flush,
  output logic        rf_we,
  output logic [4:0]  rf_addr_d,
  output logic [31:0] rf_data_d,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [63:0] instret
);

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Picks the addressed byte/half out of the raw word and extends it; LW and the
  // unused load codes pass the whole word through untouched.
  function automatic logic [31:0] align_load(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [2:0]  f3
  );
    logic        [7:0]  byte_u;
    logic        [15:0] half_u;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    case (off)
      2'd0:    byte_u = word[7:0];
      2'd1:    byte_u = word[15:8];
      2'd2:    byte_u = word[23:16];
      default: byte_u = word[31:24];
    endcase
    half_u = off[1] ? word[31:16] : word[15:0];
    byte_s = byte_u;
    half_s = half_u;
    case (f3)
      F3_LB:   align_load = 32'(byte_s);
      F3_LBU:  align_load = {24'd0, byte_u};
      F3_LH:   align_load = 32'(half_s);
      F3_LHU:  align_load = {16'd0, half_u};
      default: align_load = word;
    endcase
  endfunction

  logic        valid_q,    valid_d;
  logic        reg_we_q,   reg_we_d;
  logic [4:0]  rd_q,       rd_d;
  logic [1:0]  wb_sel_q,   wb_sel_d;
  logic [31:0] alu_out_q,  alu_out_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [2:0]  funct3_q,   funct3_d;
  logic [63:0] instret_q,  instret_d;

  logic        retire;
  logic [31:0] load_data;
  logic [31:0] wb_data;

  assign retire = valid_q & ~wb_stall;

  // Flush wins over stall; a flushed slot only needs valid cleared.
  always_comb begin
    valid_d    = valid_q;
    reg_we_d   = reg_we_q;
    rd_d       = rd_q;
    wb_sel_d   = wb_sel_q;
    alu_out_d  = alu_out_q;
    pc_plus4_d = pc_plus4_q;
    funct3_d   = funct3_q;
    if (wb_flush) begin
      valid_d = 1'b0;
    end else if (!wb_stall) begin
      valid_d    = mem_valid;
      reg_we_d   = mem_reg_we;
      rd_d       = mem_rd;
      wb_sel_d   = mem_wb_sel;
      alu_out_d  = mem_alu_out;
      pc_plus4_d = mem_pc_plus4;
      funct3_d   = mem_funct3;
    end
    instret_d = instret_q + {63'd0, retire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      reg_we_q   <= 1'b0;
      rd_q       <= 5'd0;
      wb_sel_q   <= SEL_ALU;
      alu_out_q  <= 32'd0;
      pc_plus4_q <= RST_PC4;
      funct3_q   <= 3'd0;
      instret_q  <= 64'd0;
    end else begin
      valid_q    <= valid_d;
      reg_we_q   <= reg_we_d;
      rd_q       <= rd_d;
      wb_sel_q   <= wb_sel_d;
      alu_out_q  <= alu_out_d;
      pc_plus4_q <= pc_plus4_d;
      funct3_q   <= funct3_d;
      instret_q  <= instret_d;
    end
  end

  // Write port and bypass are purely combinational from the stage register.
  always_comb begin
    load_data = align_load(dmem_rdata, alu_out_q[1:0], funct3_q);
    case (wb_sel_q)
      SEL_LOAD: wb_data = load_data;
      SEL_PC4:  wb_data = pc_plus4_q;
      default:  wb_data = alu_out_q;
    endcase
  end

  assign rf_we     = valid_q & reg_we_q & (rd_q != 5'd0) & ~wb_stall;
  assign rf_addr_d = rd_q;
  assign rf_data_d = wb_data;

  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_addr_d;
  assign fwd_data  = rf_data_d;

  assign instret = instret_q;

endmodule

// File: tb/tb_ama_riscv_writeback.sv
// Bench for ama_riscv_writeback: vector table through a scoreboard queue, plus
// hand sequences for reset, stall, flush and counter wrap.
module tb_ama_riscv_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_reg_we;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_out, mem_pc_plus4;
  logic [2:0]  mem_funct3;
  logic [31:0] dmem_rdata;
  logic        wb_stall, wb_flush;
  logic        rf_we, fwd_valid;
  logic [4:0]  rf_addr_d, fwd_rd;
  logic [31:0] rf_data_d, fwd_data;
  logic [63:0] instret;

  ama_riscv_writeback #(.RST_PC4(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_alu_out(mem_alu_out), .mem_pc_plus4(mem_pc_plus4),
    .mem_funct3(mem_funct3), .dmem_rdata(dmem_rdata),
    .wb_stall(wb_stall), .wb_flush(wb_flush),
    .rf_we(rf_we), .rf_addr_d(rf_addr_d), .rf_data_d(rf_data_d),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  vec_t  vt[17];
  exp_t  sb[$];
  exp_t  e;
  int    n_pass = 0;
  int    n_tot  = 0;
  logic  m_valid = 1'b0;
  logic [63:0] exp_cnt = 64'd0;
  logic [63:0] c0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive_mem(input logic v, input logic we, input logic [4:0] rd,
                           input logic [1:0] sel, input logic [31:0] alu,
                           input logic [31:0] pc4, input logic [2:0] f3,
                           input logic [31:0] rdata);
    mem_valid = v; mem_reg_we = we; mem_rd = rd; mem_wb_sel = sel;
    mem_alu_out = alu; mem_pc_plus4 = pc4; mem_funct3 = f3; dmem_rdata = rdata;
  endtask

  // One rising edge with the reference count/valid model, then settle 1ns.
  task automatic tick();
    logic ret;
    ret = m_valid && !wb_stall;
    @(posedge clk);
    if (ret) exp_cnt = exp_cnt + 64'd1;
    if (wb_flush) m_valid = 1'b0;
    else if (!wb_stall) m_valid = mem_valid;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{3'b000, 2'd1, 5'd7,  1'b1, 32'h1001, 32'h0, 32'h8034_F27F, 1'b1, 32'hFFFF_FFF2};
    vt[1]  = '{3'b100, 2'd1, 5'd8,  1'b1, 32'h1003, 32'h0, 32'h8034_F27F, 1'b1, 32'h0000_0080};
    vt[2]  = '{3'b000, 2'd1, 5'd9,  1'b1, 32'h1000, 32'h0, 32'h8034_F27F, 1'b1, 32'h0000_007F};
    vt[3]  = '{3'b001, 2'd1, 5'd10, 1'b1, 32'h1002, 32'h0, 32'h8034_F27F, 1'b1, 32'hFFFF_8034};
    vt[4]  = '{3'b101, 2'd1, 5'd11, 1'b1, 32'h1000, 32'h0, 32'h8034_F27F, 1'b1, 32'h0000_F27F};
    vt[5]  = '{3'b010, 2'd1, 5'd12, 1'b1, 32'h1002, 32'h0, 32'h8034_F27F, 1'b1, 32'h8034_F27F};
    vt[6]  = '{3'b000, 2'd2, 5'd5,  1'b1, 32'h0,    32'h1004, 32'h8034_F27F, 1'b1, 32'h0000_1004};
    vt[7]  = '{3'b000, 2'd2, 5'd0,  1'b1, 32'h0,    32'h1004, 32'h8034_F27F, 1'b0, 32'h0000_1004};
    vt[8]  = '{3'b001, 2'd0, 5'd9,  1'b1, 32'h1234_5678, 32'h8, 32'h8034_F27F, 1'b1, 32'h1234_5678};
    vt[9]  = '{3'b000, 2'd3, 5'd31, 1'b1, 32'hABCD_0001, 32'h8, 32'h8034_F27F, 1'b1, 32'hABCD_0001};
    vt[10] = '{3'b001, 2'd1, 5'd13, 1'b1, 32'h1003, 32'h0, 32'h8034_F27F, 1'b1, 32'hFFFF_8034};
    vt[11] = '{3'b000, 2'd1, 5'd14, 1'b1, 32'h1002, 32'h0, 32'h8034_F27F, 1'b1, 32'h0000_0034};
    vt[12] = '{3'b000, 2'd0, 5'd4,  1'b0, 32'h55,   32'h0, 32'h8034_F27F, 1'b0, 32'h0000_0055};
    vt[13] = '{3'b011, 2'd1, 5'd15, 1'b1, 32'h1001, 32'h0, 32'h8034_F27F, 1'b1, 32'h8034_F27F};
    vt[14] = '{3'b101, 2'd1, 5'd16, 1'b1, 32'h1002, 32'h0, 32'hCAFE_1234, 1'b1, 32'h0000_CAFE};
    vt[15] = '{3'b000, 2'd1, 5'd17, 1'b1, 32'h1003, 32'h0, 32'hCAFE_1234, 1'b1, 32'hFFFF_FFCA};
    vt[16] = '{3'b111, 2'd1, 5'd18, 1'b1, 32'h1003, 32'h0, 32'hCAFE_1234, 1'b1, 32'hCAFE_1234};

    rst_n = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
    drive_mem(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0);
    #12;
    chk("reset_rf_we", {63'd0, rf_we}, 64'd0);
    chk("reset_rf_addr", {59'd0, rf_addr_d}, 64'd0);
    chk("reset_rf_data", {32'd0, rf_data_d}, 64'd0);
    chk("reset_fwd", {26'd0, fwd_valid, fwd_rd, fwd_data}, 64'd0);
    chk("reset_instret", instret, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset arriving while a valid writer sits in the stage.
    drive_mem(1'b1, 1'b1, 5'd5, 2'd0, 32'h77, 32'd0, 3'd0, 32'd0);
    tick();
    chk("pre_rst_we", {63'd0, rf_we}, 64'd1);
    #2;
    rst_n = 1'b0; m_valid = 1'b0; exp_cnt = 64'd0;
    #1;
    chk("midrst_we", {63'd0, rf_we}, 64'd0);
    chk("midrst_addr", {59'd0, rf_addr_d}, 64'd0);
    chk("midrst_data", {32'd0, rf_data_d}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_mem(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0);
    tick();
    tick();
    chk("postrst_instret", instret, 64'd0);

    // Back-to-back vectors through the scoreboard.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive_mem(1'b1, vt[i].we, vt[i].rd, vt[i].sel, vt[i].alu, vt[i].pc4, vt[i].f3, vt[i].rdata);
      sb.push_back('{vt[i].exp_we, vt[i].rd, vt[i].exp_data});
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d_we", i), {63'd0, rf_we}, {63'd0, e.we});
      chk($sformatf("v%0d_addr", i), {59'd0, rf_addr_d}, {59'd0, e.addr});
      chk($sformatf("v%0d_data", i), {32'd0, rf_data_d}, {32'd0, e.data});
      chk($sformatf("v%0d_fwd", i), {26'd0, fwd_valid, fwd_rd, fwd_data},
          {26'd0, e.we, e.addr, e.data});
      chk($sformatf("v%0d_instret", i), instret, exp_cnt);
    end
    @(negedge clk);
    drive_mem(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0);
    tick();
    chk("table_instret", instret, 64'd17 + exp_cnt - exp_cnt);
    chk("table_model_cnt", instret, exp_cnt);

    // Stall for three edges, then a single unstalled edge.
    @(negedge clk);
    drive_mem(1'b1, 1'b1, 5'd3, 2'd0, 32'h33, 32'd0, 3'd0, 32'd0);
    tick();
    c0 = instret;
    wb_stall = 1'b1;
    drive_mem(1'b1, 1'b1, 5'd9, 2'd0, 32'h99, 32'd0, 3'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_we", k), {63'd0, rf_we}, 64'd0);
      chk($sformatf("stall%0d_hold", k), {27'd0, rf_addr_d, rf_data_d}, {27'd0, 5'd3, 32'h33});
      chk($sformatf("stall%0d_instret", k), instret, c0);
      tick();
    end
    wb_stall = 1'b0;
    #1;
    chk("unstall_we", {63'd0, rf_we}, 64'd1);
    chk("unstall_data", {27'd0, rf_addr_d, rf_data_d}, {27'd0, 5'd3, 32'h33});
    tick();
    chk("unstall_instret", instret, c0 + 64'd1);
    chk("unstall_next", {27'd0, rf_addr_d, rf_data_d}, {27'd0, 5'd9, 32'h99});
    drive_mem(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0);
    tick();
    chk("stall_seq_instret", instret, c0 + 64'd2);

    // Flush together with stall kills the stalled instruction.
    @(negedge clk);
    drive_mem(1'b1, 1'b1, 5'd6, 2'd0, 32'h66, 32'd0, 3'd0, 32'd0);
    tick();
    c0 = instret;
    wb_stall = 1'b1; wb_flush = 1'b1;
    drive_mem(1'b1, 1'b1, 5'd8, 2'd0, 32'h88, 32'd0, 3'd0, 32'd0);
    tick();
    wb_stall = 1'b0; wb_flush = 1'b0;
    drive_mem(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0);
    #1;
    chk("flush_we", {63'd0, rf_we}, 64'd0);
    chk("flush_instret", instret, c0);
    tick();
    chk("flush_after_instret", instret, c0);
    chk("flush_model_cnt", instret, exp_cnt);

    // Counter wrap from all ones, retiring an x0 write.
    @(negedge clk);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("wrap_forced", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_mem(1'b1, 1'b1, 5'd0, 2'd2, 32'd0, 32'h1004, 3'd0, 32'd0);
    tick();
    chk("wrap_x0_we", {63'd0, rf_we}, 64'd0);
    drive_mem(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0);
    tick();
    chk("wrap_instret", instret, 64'd0);
    chk("wrap_model_cnt", instret, exp_cnt);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
